irq_priority_controller: RTL
============================

# irq_priority_controller

- Eight-source interrupt controller that sequences the 8-to-3 priority encoding datapath in the design.
- Latches request edges into a pending register and applies a software-written mask.
- Selects the highest-priority eligible source (bit 7 highest, bit 0 lowest) and presents its 3-bit vector to a single service agent.
- Runs a raise / acknowledge / end-of-interrupt handshake so only one interrupt is in service at a time.

## Interface
Parameters:
- none; width is fixed at 8 sources, 3-bit vector.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  raw request lines; a 0→1 transition on req[i] is an event.
- mask_we  input  1  mask write strobe.
- mask_in  input  8  new mask value; 1 = source masked.
- ack  input  1  service agent accepts the presented vector.
- eoi  input  1  service agent finished the current interrupt.
- irq  output  1  interrupt request to the service agent.
- vec  output  3  vector of the selected source.
- in_service  output  1  an interrupt is acknowledged and not yet ended.
- pending  output  8  pending event register.
- mask  output  8  current mask register.

## Operation
Registers:
- req_prev[7:0] holds the previous req value.
- Edge detect: edge = req & ~req_prev.

Reset (rst=1 at a rising edge):
- Outputs: mask=8'hFF, pending=0, irq=0, vec=0, in_service=0, state=IDLE.
- req_prev loads req, so a line already high during reset is not an event.
- Reset at any point, including mid-REQ or mid-SERVICE, aborts the handshake and applies these values. No partial state survives.

Pending update, every cycle:
- pending[i] is set by edge[i].
- pending[i] is cleared only by an ack that accepts source i.
- If set and clear coincide on the same bit, set wins; the new event is kept.
- Masking does not clear pending; a masked source stays pending until unmasked and serviced.

Mask:
- When mask_we=1, mask loads mask_in at the edge.
- The new mask is visible to selection from the next cycle.

Selection:
- eligible = pending & ~mask.
- sel = index of the highest set bit of eligible (bit 7 highest).

State machine (IDLE, REQ, SERVICE):
- IDLE: if eligible≠0, load vec=sel, set irq=1, go to REQ. Otherwise stay.
- REQ: irq=1 and vec is frozen.
  - A later higher-priority event, or masking the latched source, does not change vec.
  - On ack: clear pending[vec], set irq=0 and in_service=1, go to SERVICE.
- SERVICE: vec is held.
  - On eoi: set in_service=0 and go to IDLE. vec keeps its last value.
- ack outside REQ and eoi outside SERVICE are ignored.
- ack and eoi together in REQ: only ack is acted on.

## Timing
- Event latency: req[i] rises before edge k → pending[i]=1 after edge k → irq=1 and vec valid after edge k+1. That is 2 cycles, if the controller is IDLE and i is unmasked.
- ack sampled at edge a → after a: irq=0, in_service=1, pending bit cleared.
- eoi sampled at edge e → after e: in_service=0, state IDLE.
  - Earliest next irq is after edge e+1, one IDLE cycle between interrupts.
- Unmasking a pending source: mask_we at edge m → irq after edge m+1 at earliest.
- All outputs are registered; no combinational path from inputs to outputs.
- ack and eoi are single-cycle strobes. A held ack has no effect after the first accepted cycle. A held eoi has no effect after the return to IDLE.

## Test plan
- Reset with req=8'h81 held high, then write mask=0 → no irq; pending stays 0 because no edge occurred.
- mask=0; raise req[2] and req[5] in the same cycle → 2 cycles later irq=1, vec=5. ack → pending=8'h04. eoi, then one idle cycle → irq=1, vec=2.
- mask=0; raise req[3] → REQ with vec=3. Then raise req[7] before ack → vec stays 3. ack and eoi → next irq has vec=7.
- mask=8'hFF; raise req[6] → pending=8'h40, irq stays 0. Write mask=8'hBF → irq=1, vec=6, 2 cycles after the write edge.
- In REQ with vec=4, a new req[4] edge arrives in the same cycle as ack → after the edge pending[4]=1 and in_service=1. After eoi → irq again with vec=4.
- Assert rst mid-SERVICE → after the edge irq=0, in_service=0, pending=0, mask=8'hFF. Later ack or eoi strobes → no state change.

Source files
------------

// File: rtl/irq_priority_controller.sv
// Eight-source priority interrupt controller: edge-latched pending bits, software mask,
// and a raise / ack / eoi handshake that keeps at most one interrupt in service.
module irq_priority_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       mask_we,
  input  logic [7:0] mask_in,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [2:0] vec,
  output logic       in_service,
  output logic [7:0] pending,
  output logic [7:0] mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] req_prev_q, req_prev_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic       irq_q, irq_d;
  logic [2:0] vec_q, vec_d;
  logic       in_service_q, in_service_d;

  logic [7:0] req_edge;
  logic [7:0] eligible;
  logic [7:0] ack_clear;
  logic [2:0] sel;

  assign req_edge = req & ~req_prev_q;
  assign eligible = pending_q & ~mask_q;

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) begin
        sel = 3'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    irq_d        = irq_q;
    vec_d        = vec_q;
    in_service_d = in_service_q;
    ack_clear    = 8'h00;
    req_prev_d   = req;
    mask_d       = mask_we ? mask_in : mask_q;

    unique case (state_q)
      IDLE: begin
        if (eligible != 8'h00) begin
          vec_d   = sel;
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          ack_clear[vec_q] = 1'b1;
          irq_d            = 1'b0;
          in_service_d     = 1'b1;
          state_d          = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        irq_d        = 1'b0;
        in_service_d = 1'b0;
        state_d      = IDLE;
      end
    endcase

    // A fresh edge on the source being acknowledged must survive the ack.
    pending_d = (pending_q & ~ack_clear) | req_edge;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_prev_q   <= req;
      pending_q    <= 8'h00;
      mask_q       <= 8'hFF;
      irq_q        <= 1'b0;
      vec_q        <= 3'd0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_prev_q   <= req_prev_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      irq_q        <= irq_d;
      vec_q        <= vec_d;
      in_service_q <= in_service_d;
    end
  end

  assign irq        = irq_q;
  assign vec        = vec_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule
